// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with a UART transmit sequence.
// Optional feature macro: MCU_BRANCH_JUMP_EN enables the BRANCH/JUMP states
// and the beq/bne/j decode; without it those opcodes fall back to FETCH.
module multicycle_ctrl #(
  parameter int TX_TIMEOUT        = 1023,
  parameter bit RESUME_AFTER_UART = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       TX_flag,
  output logic       PCen,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       DRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [4:0] ALUControl,
  output logic       ALU_en,
  output logic [1:0] PCSrc,
  output logic       Page,
  output logic       SerialOutEn,
  output logic       TxTimeout,
  output logic       Busy
);

  typedef enum logic [4:0] {
    IDLE, FETCH, DECODE, EX_R, EX_I, EX_MEM, MEM_LD, MEM_ST, WB_R, WB_I, WB_L,
    BRANCH, JUMP, UART_EX, UART_TX, UART_WAIT, UART_DONE
  } state_t;

  // Counter only needs to reach TX_TIMEOUT-1; a zero timeout never fires.
  localparam bit          TO_EN = (TX_TIMEOUT != 0);
  localparam int          CW    = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = TO_EN ? CW'(TX_TIMEOUT - 1) : '0;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_txto;
  logic            r_is_sw;
  logic            r_is_sll;
  logic [4:0]      r_alu_ctrl;
  logic [4:0]      w_alu_dec;
  logic            w_timeout;

`ifdef MCU_BRANCH_JUMP_EN
  logic            r_is_bne;
`else
  logic            w_unused_zero;
  assign w_unused_zero = Zero;
`endif

  // ALU operation implied by the opcode/function being decoded
  always_comb begin
    w_alu_dec = 5'b00000;
    if (Op == 6'b000000) begin
      case (Funct)
        6'b000000: w_alu_dec = 5'b11000;
        6'b100010: w_alu_dec = 5'b00001;
        6'b100101: w_alu_dec = 5'b00110;
        default:   w_alu_dec = 5'b00000;
      endcase
    end else if (Op == 6'b001100) begin
      w_alu_dec = 5'b00101;
    end else if (Op == 6'b001101) begin
      w_alu_dec = 5'b00110;
    end
  end

  // TX_flag wins over a coincident timeout
  assign w_timeout = TO_EN && (r_state == UART_WAIT) && !TX_flag && (r_cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Instruction attributes latched while decoding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_sw    <= 1'b0;
      r_is_sll   <= 1'b0;
      r_alu_ctrl <= 5'b00000;
`ifdef MCU_BRANCH_JUMP_EN
      r_is_bne   <= 1'b0;
`endif
    end else if (r_state == DECODE) begin
      r_is_sw    <= (Op == 6'b101011);
      r_is_sll   <= (Op == 6'b000000) && (Funct == 6'b000000);
      r_alu_ctrl <= w_alu_dec;
`ifdef MCU_BRANCH_JUMP_EN
      r_is_bne   <= (Op == 6'b000101);
`endif
    end
  end

  // UART wait counter (zero outside UART_WAIT) and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_txto <= 1'b0;
    end else begin
      r_cnt <= (r_state == UART_WAIT) ? r_cnt + CW'(1) : '0;
      if (r_state == IDLE && start) r_txto <= 1'b0;
      else if (w_timeout)           r_txto <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   w_next = DECODE;
      DECODE: begin
        w_next = FETCH;
        case (Op)
          6'b000000: begin
            if (Funct == 6'b000000 || Funct == 6'b100000 ||
                Funct == 6'b100010 || Funct == 6'b100101) w_next = EX_R;
            else if (Funct == 6'b010100)                  w_next = UART_EX;
          end
          6'b001000, 6'b001100, 6'b001101: w_next = EX_I;
          6'b100011, 6'b101011:            w_next = EX_MEM;
`ifdef MCU_BRANCH_JUMP_EN
          6'b000100, 6'b000101:            w_next = BRANCH;
          6'b000010:                       w_next = JUMP;
`endif
          default:                         w_next = FETCH;
        endcase
      end
      EX_R:      w_next = WB_R;
      EX_I:      w_next = WB_I;
      EX_MEM:    w_next = r_is_sw ? MEM_ST : MEM_LD;
      MEM_LD:    w_next = WB_L;
      MEM_ST, WB_R, WB_I, WB_L, BRANCH, JUMP: w_next = FETCH;
      UART_EX:   w_next = UART_TX;
      UART_TX:   w_next = UART_WAIT;
      UART_WAIT: if (TX_flag || w_timeout) w_next = UART_DONE;
      UART_DONE: w_next = RESUME_AFTER_UART ? FETCH : IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Moore output decode; PCen in BRANCH additionally looks at Zero
  always_comb begin
    PCen = 1'b0; IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; DRWrite = 1'b0;
    RegWrite = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0; ALUSrcA = 1'b0;
    ALUSrcB = 2'b00; ALUControl = 5'b00000; ALU_en = 1'b0; PCSrc = 2'b00;
    Page = 1'b0; SerialOutEn = 1'b0;
    case (r_state)
      FETCH: begin
        PCen = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'b01;
      end
      EX_R: begin
        ALUSrcA = 1'b1; ALU_en = 1'b1; ALUControl = r_alu_ctrl;
        ALUSrcB = r_is_sll ? 2'b11 : 2'b00;
      end
      EX_I, EX_MEM: begin
        ALUSrcA = 1'b1; ALU_en = 1'b1; ALUControl = r_alu_ctrl; ALUSrcB = 2'b10;
      end
      UART_EX: begin
        ALUSrcA = 1'b1; ALU_en = 1'b1; ALUControl = 5'b01111;
      end
      MEM_ST:  begin IorD = 1'b1; MemWrite = 1'b1; end
      MEM_LD:  begin IorD = 1'b1; DRWrite = 1'b1; Page = 1'b1; end
      WB_R:    begin RegWrite = 1'b1; RegDst = 1'b1; end
      WB_I:    RegWrite = 1'b1;
      WB_L:    begin RegWrite = 1'b1; MemtoReg = 1'b1; end
`ifdef MCU_BRANCH_JUMP_EN
      BRANCH:  begin PCSrc = 2'b01; PCen = r_is_bne ? ~Zero : Zero; end
      JUMP:    begin PCSrc = 2'b10; PCen = 1'b1; end
`endif
      UART_TX: SerialOutEn = 1'b1;
      default: ;
    endcase
  end

  assign TxTimeout = r_txto;
  assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (TX_TIMEOUT = 8).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       TX_flag = 1'b0;
  logic       PCen, IorD, MemWrite, IRWrite, DRWrite, RegWrite, RegDst, MemtoReg;
  logic       ALUSrcA, ALU_en, Page, SerialOutEn, TxTimeout, Busy;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.TX_TIMEOUT(8), .RESUME_AFTER_UART(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .Op(Op), .Funct(Funct),
    .Zero(Zero), .TX_flag(TX_flag), .PCen(PCen), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .DRWrite(DRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ALU_en(ALU_en), .PCSrc(PCSrc), .Page(Page), .SerialOutEn(SerialOutEn),
    .TxTimeout(TxTimeout), .Busy(Busy)
  );

  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {PCen, IorD, MemWrite, IRWrite, DRWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUControl, ALU_en, PCSrc, Page, SerialOutEn,
                TxTimeout, Busy};

  function automatic logic [22:0] ev(input logic pcen, iord, memw, irw, drw, regw,
      regdst, m2r, srca, input logic [1:0] srcb, input logic [4:0] aluc,
      input logic alue, input logic [1:0] pcsrc, input logic page, sout, txto, busy);
    return {pcen, iord, memw, irw, drw, regw, regdst, m2r, srca, srcb, aluc, alue,
            pcsrc, page, sout, txto, busy};
  endfunction

  localparam logic [22:0] V_IDLE   = '0;
  localparam logic [22:0] V_BUSY   = ev(0,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b00,0,0,0,1);
  localparam logic [22:0] V_FETCH  = ev(1,0,0,1,0,0,0,0,0,2'b01,5'b00000,0,2'b00,0,0,0,1);
  localparam logic [22:0] V_EXADD  = ev(0,0,0,0,0,0,0,0,1,2'b10,5'b00000,1,2'b00,0,0,0,1);
  localparam logic [22:0] V_WBI    = ev(0,0,0,0,0,1,0,0,0,2'b00,5'b00000,0,2'b00,0,0,0,1);
  localparam logic [22:0] V_WBR    = ev(0,0,0,0,0,1,1,0,0,2'b00,5'b00000,0,2'b00,0,0,0,1);
  localparam logic [22:0] V_MEMLD  = ev(0,1,0,0,1,0,0,0,0,2'b00,5'b00000,0,2'b00,1,0,0,1);
  localparam logic [22:0] V_WBL    = ev(0,0,0,0,0,1,0,1,0,2'b00,5'b00000,0,2'b00,0,0,0,1);
  localparam logic [22:0] V_MEMST  = ev(0,1,1,0,0,0,0,0,0,2'b00,5'b00000,0,2'b00,0,0,0,1);
  localparam logic [22:0] V_UEX    = ev(0,0,0,0,0,0,0,0,1,2'b00,5'b01111,1,2'b00,0,0,0,1);
  localparam logic [22:0] V_UTX    = ev(0,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b00,0,1,0,1);
  localparam logic [22:0] V_DONETO = ev(0,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b00,0,0,1,1);
  localparam logic [22:0] V_IDLETO = ev(0,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b00,0,0,1,0);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Async reset pulse; released on a falling edge so the FSM sits in IDLE
  task automatic do_reset();
    start = 0; Zero = 0; TX_flag = 0;
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 0; #1;
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk); reset = 1;
    tick();
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL idle_hold_no_start: got %h expected %h", obs, V_IDLE);
    end
  endtask

  task automatic run_seq(input string name, input logic [22:0] exp_q[$]);
    foreach (exp_q[i]) begin
      if (i > 0) tick();
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0]  ops[3]  = '{6'b001000, 6'b001100, 6'b001101};
    logic [4:0]  aluc[3] = '{5'b00000, 5'b00101, 5'b00110};
    foreach (ops[i]) begin
      do_reset(); Op = ops[i]; Funct = 6'b000000; go();
      run_seq("itype", '{V_FETCH, V_BUSY,
        ev(0,0,0,0,0,0,0,0,1,2'b10,aluc[i],1,2'b00,0,0,0,1), V_WBI, V_FETCH});
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn[4]   = '{6'b100000, 6'b100010, 6'b100101, 6'b000000};
    logic [4:0] aluc[4] = '{5'b00000, 5'b00001, 5'b00110, 5'b11000};
    logic [1:0] srcb[4] = '{2'b00, 2'b00, 2'b00, 2'b11};
    foreach (fn[i]) begin
      do_reset(); Op = 6'b000000; Funct = fn[i]; go();
      run_seq("rtype", '{V_FETCH, V_BUSY,
        ev(0,0,0,0,0,0,0,0,1,srcb[i],aluc[i],1,2'b00,0,0,0,1), V_WBR, V_FETCH});
    end
  endtask

  task automatic test_mem();
    do_reset(); Op = 6'b100011; go();
    run_seq("lw", '{V_FETCH, V_BUSY, V_EXADD, V_MEMLD, V_WBL, V_FETCH});
    do_reset(); Op = 6'b101011; go();
    run_seq("sw", '{V_FETCH, V_BUSY, V_EXADD, V_MEMST, V_FETCH});
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops[4] = '{6'b000100, 6'b000101, 6'b000101, 6'b000010};
    logic        zs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
`ifdef MCU_BRANCH_JUMP_EN
    logic [22:0] ex[4];
    ex[0] = ev(1,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b01,0,0,0,1);
    ex[1] = ev(0,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b01,0,0,0,1);
    ex[2] = ev(1,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b01,0,0,0,1);
    ex[3] = ev(1,0,0,0,0,0,0,0,0,2'b00,5'b00000,0,2'b10,0,0,0,1);
`endif
    foreach (ops[i]) begin
      do_reset(); Op = ops[i]; Zero = zs[i]; go();
`ifdef MCU_BRANCH_JUMP_EN
      run_seq("branch_jump", '{V_FETCH, V_BUSY, ex[i], V_FETCH});
`else
      run_seq("branch_jump_off", '{V_FETCH, V_BUSY, V_FETCH});
`endif
    end
  endtask

  task automatic test_uart_timeout();
    logic [22:0] q[$];
    q = '{V_FETCH, V_BUSY, V_UEX, V_UTX};
    for (int k = 0; k < 8; k++) q.push_back(V_BUSY);
    q.push_back(V_DONETO); q.push_back(V_IDLETO); q.push_back(V_IDLETO);
    do_reset(); Op = 6'b000000; Funct = 6'b010100; go();
    run_seq("uart_timeout", q);
    // Sticky flag is cleared by reset
    #2 reset = 0; #1;
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL timeout_reset_clear: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk); reset = 1;
    // Sticky flag is cleared on leaving IDLE
    Op = 6'b000000; Funct = 6'b010100; go();
    run_seq("uart_timeout2", q);
    go();
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++; $display("FAIL timeout_start_clear: got %h expected %h", obs, V_FETCH);
    end
  endtask

  task automatic test_uart_flag();
    do_reset(); Op = 6'b000000; Funct = 6'b010100; go();
    run_seq("uart_flag_a", '{V_FETCH, V_BUSY, V_UEX, V_UTX, V_BUSY, V_BUSY});
    TX_flag = 1; tick(); TX_flag = 0;
    n_checks++;
    if (obs !== V_BUSY) begin
      n_fail++; $display("FAIL uart_flag_done: got %h expected %h", obs, V_BUSY);
    end
    tick();
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL uart_flag_idle: got %h expected %h", obs, V_IDLE);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(); Op = 6'b000000; Funct = 6'b010100; go();
    run_seq("mid_tx_pre", '{V_FETCH, V_BUSY, V_UEX, V_UTX});
    #2 reset = 0; #1;
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL reset_in_uart_tx: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk); reset = 1;
    go();
    run_seq("mid_wait_pre", '{V_FETCH, V_BUSY, V_UEX, V_UTX, V_BUSY, V_BUSY});
    #2 reset = 0; #1;
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL reset_in_uart_wait: got %h expected %h", obs, V_IDLE);
    end
    @(negedge clk); reset = 1;
    Op = 6'b111111; go();
    run_seq("illegal_op", '{V_FETCH, V_BUSY, V_FETCH});
  endtask

  initial begin
    test_reset();
    test_itype();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_uart_timeout();
    test_uart_flag();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
